second_tick_driver: RTL and testbench
=====================================

# second_tick_driver

Sequential stimulus-and-check stage that sits directly upstream of the `second_tick` gate (out = a AND NOT b). On `start` it drives the DUT inputs `a`/`b` through the four input combinations 00, 10, 01, 11 (as a,b). It holds each combination for `HOLD_CYCLES` clocks and samples the DUT response on the last held cycle. It compares each sample against a parameterised expected truth table and reports a per-combination fail mask, an error count and a pass/done verdict. This turns the level's open-loop testbench into a self-checking hardware harness.

## Interface
Parameters:
- `HOLD_CYCLES`, default 10: clocks each combination is held; legal range ≥1.
- `EXPECTED`, default 4'b0010: bit i is the expected DUT output for combination i. Index i = {b,a}: i=0 is a0b0, i=1 is a1b0, i=2 is a0b1, i=3 is a1b1.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a run; sampled in IDLE and DONE only.
- `dut_out`  in  1  DUT output; treated as combinational from `a`/`b`.
- `a`  out  1  registered DUT input a.
- `b`  out  1  registered DUT input b.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE until the next `start`.
- `pass`  out  1  valid when `done`=1; 1 iff `fail_mask`==0.
- `fail_mask`  out  4  bit i set if combination i mismatched.
- `err_count`  out  3  number of mismatches, 0..4.

## Operation
- FSM states: IDLE, RUN, DONE. Internal state is `idx[1:0]` (current combination) and a hold counter `cnt` of width $clog2(HOLD_CYCLES+1).
- IDLE: `a`=`b`=0. When `start`=1, go to RUN with `idx`=0, `cnt`=0, `fail_mask`=0, `err_count`=0, {b,a}=00.
- RUN, `cnt` < HOLD_CYCLES-1: increment `cnt`; `a`/`b` stable.
- RUN, `cnt`==HOLD_CYCLES-1 (sample edge):
  - Compare `dut_out` with `EXPECTED[idx]`.
  - On mismatch, set `fail_mask[idx]` and increment `err_count`.
  - Then set `cnt`=0.
  - If `idx`<3: `idx`+1 and drive the next combination ({b,a}=idx+1) on the same edge.
  - If `idx`==3: go to DONE and drive `a`=`b`=0.
- DONE: `done`=1, `pass`=(`fail_mask`==0). Hold results until `start`. On `start`, behave exactly as IDLE+start: clear results and restart.
- `start` while in RUN is ignored; there is no abort input.
- `err_count` cannot exceed 4 and needs no saturation logic. `err_count` always equals the popcount of `fail_mask`.
- Reset: asynchronous, immediate, including mid-RUN. All outputs go to 0 (`a`, `b`, `busy`, `done`, `pass`, `fail_mask`, `err_count`) and the FSM returns to IDLE. No partial results are retained.

## Timing
- `start` high at edge T: `busy`=1 and {b,a}=00 from T+1.
- Combination k is driven during cycles T+1+k·HOLD_CYCLES through T+(k+1)·HOLD_CYCLES.
- Sample for combination k is taken at edge T+(k+1)·HOLD_CYCLES. The registered `fail_mask`/`err_count` update is visible after that edge.
- `busy`=0, `done`=1 and final `pass` are valid from T+1+4·HOLD_CYCLES. Total RUN length is exactly 4·HOLD_CYCLES cycles.
- `dut_out` must settle within one cycle of an `a`/`b` change. This is satisfied for any HOLD_CYCLES ≥1 with a combinational DUT.
- `pass` is 0 whenever `done`=0.

## Test plan
- Correct DUT (a & ~b), HOLD_CYCLES=10, `start` pulse at T → {b,a} sequence 00,01,10,11 per 10 cycles; `done`=1 at T+41; `pass`=1, `fail_mask`=0000, `err_count`=0.
- Faulty DUT (a & b) → `fail_mask`=1010, `err_count`=2, `pass`=0.
- `dut_out` stuck at 1 → `fail_mask`=1101, `err_count`=3, `pass`=0. Then restart from DONE with a correct DUT → results cleared at T'+1; final `pass`=1.
- `start` pulsed repeatedly during RUN → no effect; `done` still at T+41 from the original start.
- `rst_n` asserted at T+15 → all outputs 0 immediately with no clock required; FSM in IDLE; next `start` runs a full clean sequence.
- HOLD_CYCLES=1, correct DUT → `a`/`b` change every cycle; `done` at T+5; `pass`=1.

Source files
------------

// File: rtl/second_tick_driver.sv
// Self-checking stimulus stage for the second_tick gate: walks {b,a} through 00,01,10,11,
// samples the DUT on the last held cycle of each combination and reports mask/count/verdict.
module second_tick_driver #(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] EXPECTED    = 4'b0010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  localparam int            CW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic [3:0]    mask_nxt;

  assign mismatch = (dut_out != EXPECTED[idx]);

  always_comb begin
    mask_nxt = fail_mask;
    if (mismatch) mask_nxt[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
      err_count <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A restart from DONE is indistinguishable from a start out of IDLE.
          if (start) begin
            state     <= RUN;
            idx       <= 2'd0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            err_count <= 3'd0;
          end
        end
        RUN: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt       <= '0;
            fail_mask <= mask_nxt;
            if (mismatch) err_count <= err_count + 3'd1;
            if (idx != 2'd3) begin
              idx    <= idx + 2'd1;
              {b, a} <= idx + 2'd1;
            end else begin
              state <= DONE;
              a     <= 1'b0;
              b     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mask_nxt == 4'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_second_tick_driver.sv
// Bench for second_tick_driver: two instances (HOLD_CYCLES=10 and 1) driving a modelled gate.
module tb_second_tick_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start10 = 1'b0, start1 = 1'b0;
  logic dout10, dout1;
  logic a10, b10, busy10, done10, pass10;
  logic a1, b1, busy1, done1, pass1;
  logic [3:0] fm10, fm1;
  logic [2:0] ec10, ec1;
  int mode = 0;
  logic use1 = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {logic [1:0] ba; logic [3:0] mask; logic [2:0] err;} cyc_t;
  typedef struct {logic [3:0] mask; logic [2:0] err; logic pass;} res_t;
  cyc_t cyc_q[$];
  res_t res_q[$];

  always #5 clk = ~clk;

  // Modelled DUT: 0 = correct a&~b, 1 = faulty a&b, 2 = stuck at 1.
  function automatic logic model_dut(input int m, input logic ai, input logic bi);
    case (m)
      0:       return ai & ~bi;
      1:       return ai & bi;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] popcnt(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  assign dout10 = model_dut(mode, a10, b10);
  assign dout1  = model_dut(mode, a1, b1);

  second_tick_driver #(.HOLD_CYCLES(10), .EXPECTED(4'b0010)) u_d10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .dut_out(dout10),
    .a(a10), .b(b10), .busy(busy10), .done(done10), .pass(pass10),
    .fail_mask(fm10), .err_count(ec10)
  );

  second_tick_driver #(.HOLD_CYCLES(1), .EXPECTED(4'b0010)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dout1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fm1), .err_count(ec1)
  );

  logic [1:0] obs_ba;
  logic [2:0] obs_ctl;
  logic [3:0] obs_fm;
  logic [2:0] obs_ec;
  assign obs_ba  = use1 ? {b1, a1} : {b10, a10};
  assign obs_ctl = use1 ? {busy1, done1, pass1} : {busy10, done10, pass10};
  assign obs_fm  = use1 ? fm1 : fm10;
  assign obs_ec  = use1 ? ec1 : ec10;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a10, b10, busy10, done10, pass10, fm10, ec10} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_d10: got %b, want 0", {a10, b10, busy10, done10, pass10, fm10, ec10});
    end
    n_checks++;
    if ({a1, b1, busy1, done1, pass1, fm1, ec1} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_d1: got %b, want 0", {a1, b1, busy1, done1, pass1, fm1, ec1});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({a10, b10, busy10, done10} !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b, want 0000", {a10, b10, busy10, done10});
    end
  endtask

  // One full run on the selected instance; expectations come from the gate model
  // compared against the ideal a&~b truth table.
  task automatic run(input int h, input int mode_i, input bit pulse, input string name);
    logic [3:0] fm;
    logic [3:0] pm;
    logic [1:0] ii;
    cyc_t c;
    res_t r;
    mode = mode_i;
    use1 = (h == 1);
    fm = 4'd0;
    for (int i = 0; i < 4; i++) begin
      ii = 2'(i);
      if (model_dut(mode_i, ii[0], ii[1]) !== (ii[0] & ~ii[1])) fm[i] = 1'b1;
    end
    for (int j = 0; j < 4 * h; j++) begin
      c.ba = 2'(j / h);
      pm = fm & 4'((1 << (j / h)) - 1);
      c.mask = pm;
      c.err = popcnt(pm);
      cyc_q.push_back(c);
    end
    r.mask = fm;
    r.err = popcnt(fm);
    r.pass = (fm == 4'd0);
    res_q.push_back(r);

    if (h == 1) start1 = 1'b1; else start10 = 1'b1;
    tick();
    start1 = 1'b0;
    start10 = 1'b0;
    for (int j = 0; j < 4 * h; j++) begin
      c = cyc_q.pop_front();
      n_checks++;
      if (obs_ctl !== 3'b100 || obs_ba !== c.ba || obs_fm !== c.mask || obs_ec !== c.err) begin
        n_fail++;
        $display("FAIL %s_cyc%0d: got ctl=%b ba=%b mask=%b err=%0d, want ctl=100 ba=%b mask=%b err=%0d",
                 name, j, obs_ctl, obs_ba, obs_fm, obs_ec, c.ba, c.mask, c.err);
      end
      if (pulse && (j % 7 == 3) && (j < 4 * h - 1)) begin
        if (h == 1) start1 = 1'b1; else start10 = 1'b1;
      end else begin
        start1 = 1'b0;
        start10 = 1'b0;
      end
      tick();
    end
    start1 = 1'b0;
    start10 = 1'b0;
    r = res_q.pop_front();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_ctl !== {1'b0, 1'b1, r.pass} || obs_ba !== 2'b00 || obs_fm !== r.mask || obs_ec !== r.err) begin
        n_fail++;
        $display("FAIL %s_done%0d: got ctl=%b ba=%b mask=%b err=%0d, want ctl=01%b ba=00 mask=%b err=%0d",
                 name, k, obs_ctl, obs_ba, obs_fm, obs_ec, r.pass, r.mask, r.err);
      end
      tick();
    end
  endtask

  task automatic test_correct();     run(10, 0, 1'b0, "correct");    endtask
  task automatic test_faulty();      run(10, 1, 1'b0, "faulty");     endtask
  task automatic test_stuck_restart();
    run(10, 2, 1'b0, "stuck");
    run(10, 0, 1'b0, "restart");
  endtask
  task automatic test_start_in_run(); run(10, 1, 1'b1, "start_in_run"); endtask
  task automatic test_hold1();
    run(1, 0, 1'b0, "hold1_ok");
    run(1, 1, 1'b0, "hold1_faulty");
  endtask

  task automatic test_midrun_reset();
    use1 = 1'b0;
    mode = 2;
    start10 = 1'b1;
    tick();
    start10 = 1'b0;
    repeat (15) tick();
    n_checks++;
    if (ec10 !== 3'd1 || busy10 !== 1'b1 || {b10, a10} !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_reset: got err=%0d busy=%b ba=%b, want err=1 busy=1 ba=01", ec10, busy10, {b10, a10});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a10, b10, busy10, done10, pass10, fm10, ec10} !== 12'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %b, want 0", {a10, b10, busy10, done10, pass10, fm10, ec10});
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({a10, b10, busy10, done10, pass10, fm10, ec10} !== 12'd0) begin
      n_fail++;
      $display("FAIL idle_after_midrun: got %b, want 0", {a10, b10, busy10, done10, pass10, fm10, ec10});
    end
    run(10, 0, 1'b0, "after_reset");
  endtask

  initial begin
    #2;
    test_reset();
    test_correct();
    test_faulty();
    test_stuck_restart();
    test_start_in_run();
    test_midrun_reset();
    test_hold1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
